instr_fetch_unit: RTL and testbench

- Upstream neighbour of the control unit. Owns the program counter.
- Fetches one 32-bit instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Presents the instruction to decode with a valid/ready handshake.
- Computes the next PC from PCSrc and the branch/jump target when decode accepts the instruction; supports a flush/redirect that can arrive at any time.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word at a time over req/gnt/rvalid and hands it to
// decode over valid/ready. Define FETCH_MISALIGN_TRAP_EN to halt on a misaligned next PC instead of masking it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        PCSrc,
  input  logic [31:0] pc_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      state;
  logic        drop;
  logic        stale;
  logic        flush_misal;
  logic        accept_misal;
  logic [31:0] accept_pc;

  function automatic logic [31:0] next_pc(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  assign flush_misal  = |flush_pc[1:0];
  assign accept_misal = PCSrc && (|pc_target[1:0]);
`else
  assign flush_misal  = 1'b0;
  assign accept_misal = 1'b0;
`endif

  assign pc_plus4   = pc + 32'd4;
  assign accept_pc  = PCSrc ? pc_target : pc_plus4;
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc;
  assign fetch_busy = (state == S_REQ) || (state == S_WAIT);

  // Memory still owes a response after this cycle; a redirect must swallow it.
  assign stale = ((state == S_REQ) && imem_gnt && !imem_rvalid) ||
                 ((state == S_WAIT) && !imem_rvalid) ||
                 ((state == S_HALT) && drop && !imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      drop        <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else if (flush) begin
      pc          <= next_pc(flush_pc);
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      drop        <= stale;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misaligned <= flush_misal;
`endif
      if (flush_misal) state <= S_HALT;
      else if (stale)  state <= S_WAIT;
      else             state <= S_REQ;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            if (imem_rvalid) begin
              instruction <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              instruction <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc          <= next_pc(accept_pc);
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            if (accept_misal) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              fetch_misaligned <= 1'b1;
`endif
              state <= S_HALT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_HALT: begin
          if (imem_rvalid) drop <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable memory responder plus a PC-sequence model
// (next PC from accepts/flushes, instruction content from a fixed address->word map).
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc;
  logic [31:0] pc_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_busy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int          checks = 0;
  int          errors = 0;
  int          gnt_lat = 0;
  int          rv_lat = 1;
  bit          corrupt = 1'b0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4), .PCSrc(PCSrc), .pc_target(pc_target),
    .flush(flush), .flush_pc(flush_pc), .fetch_busy(fetch_busy)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  // Memory: grants after gnt_lat request cycles, returns data rv_lat cycles after grant.
  initial begin : mem_model
    int          cnt;
    int          waited;
    bit          pend;
    logic [31:0] a;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    cnt = 0; waited = 0; pend = 1'b0; a = '0;
    forever begin
      @(posedge clk); #1;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0; waited = 0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = corrupt ? 32'hDEAD_BEEF : mem_word(a);
          pend = 1'b0;
        end
      end else if (imem_req) begin
        if (waited < gnt_lat) begin
          waited++;
        end else begin
          waited = 0;
          imem_gnt = 1'b1;
          a = imem_addr;
          if (rv_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = corrupt ? 32'hDEAD_BEEF : mem_word(a);
          end else begin
            pend = 1'b1; cnt = rv_lat;
          end
        end
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req && imem_gnt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    instr_ready = 0; PCSrc = 0; pc_target = '0; flush = 0; flush_pc = '0;
    gnt_lat = 0; rv_lat = 1; corrupt = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h4); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, NOP); end
    checks++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_req req %b busy %b exp 0 0", imem_req, fetch_busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_cycle req got %b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_busy !== 1'b1) begin
      errors++; $display("FAIL first_req req %b addr %h busy %b exp 1 00000000 1", imem_req, imem_addr, fetch_busy);
    end
    m_pc = 32'h0;
  endtask

  task automatic test_first_fetch();
    bit ok;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_valid timeout got 0 exp 1"); end
    checks++; if (instruction !== 32'h0050_0093 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL first_instr got %h pc %h pc4 %h exp 00500093 0 4", instruction, pc, pc_plus4);
    end
    instr_ready = 1; @(negedge clk); instr_ready = 0;
    m_pc = 32'h4;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== m_pc) begin errors++; $display("FAIL second_req ok %b addr %h exp %h", ok, imem_addr, m_pc); end
    wait_valid(ok);
    checks++; if (!ok || pc !== m_pc || instruction !== mem_word(m_pc)) begin
      errors++; $display("FAIL second_instr pc %h instr %h exp %h %h", pc, instruction, m_pc, mem_word(m_pc));
    end
  endtask

  task automatic test_hold_stall();
    bit ok;
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || pc !== m_pc || instruction !== mem_word(m_pc) || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold_stable v %b pc %h instr %h req %b exp 1 %h %h 0", instr_valid, pc, instruction, imem_req, m_pc, mem_word(m_pc));
      end
    end
    instr_ready = 1; @(negedge clk); instr_ready = 0;
    m_pc = m_pc + 32'd4;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== m_pc) begin errors++; $display("FAIL hold_next_req ok %b addr %h exp %h", ok, imem_addr, m_pc); end
    wait_valid(ok);
  endtask

  task automatic test_branch();
    bit ok;
    checks++; if (pc !== 32'h8 || pc_plus4 !== 32'hC) begin errors++; $display("FAIL branch_pc pc %h pc4 %h exp 8 c", pc, pc_plus4); end
    instr_ready = 1; PCSrc = 1; pc_target = 32'h40;
    @(negedge clk);
    instr_ready = 0; PCSrc = 0;
    m_pc = 32'h40;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h40) begin errors++; $display("FAIL branch_req ok %b addr %h exp 40", ok, imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || instruction !== mem_word(32'h40)) begin errors++; $display("FAIL branch_instr got %h exp %h", instruction, mem_word(32'h40)); end
  endtask

  task automatic test_flush_wait();
    bit ok;
    bit seen;
    rv_lat = 3;
    instr_ready = 1; @(negedge clk); instr_ready = 0;
    m_pc = m_pc + 32'd4;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_busy && !imem_req) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL flush_reach_wait timeout got 0 exp 1"); end
    flush = 1; flush_pc = 32'h100; corrupt = 1'b1;
    @(negedge clk);
    flush = 0;
    m_pc = 32'h100;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (imem_rvalid) begin seen = 1'b1; corrupt = 1'b0; end
    end
    corrupt = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL flush_stale_rvalid seen %b exp 1", seen); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || instruction === 32'hDEAD_BEEF) begin
      errors++; $display("FAIL flush_dropped v %b instr %h exp 0 %h", instr_valid, instruction, NOP);
    end
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h100) begin errors++; $display("FAIL flush_req ok %b addr %h exp 100", ok, imem_addr); end
    wait_valid(ok);
    checks++; if (!ok || instruction !== mem_word(32'h100) || pc !== 32'h100) begin
      errors++; $display("FAIL flush_instr got %h pc %h exp %h 100", instruction, pc, mem_word(32'h100));
    end
    rv_lat = 1;
  endtask

  task automatic test_zero_latency();
    logic [31:0] addrs[$];
    int          acc_at[$];
    bit          ok;
    gnt_lat = 0; rv_lat = 0;
    flush = 1; flush_pc = 32'h0;
    m_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      flush = 0;
      if (imem_req && imem_gnt) addrs.push_back(imem_addr);
      instr_ready = (i < 11);
      if (instr_valid && instr_ready) begin
        acc_at.push_back(i);
        checks++; if (pc !== m_pc || instruction !== mem_word(m_pc)) begin
          errors++; $display("FAIL zl_instr pc %h instr %h exp %h %h", pc, instruction, m_pc, mem_word(m_pc));
        end
        m_pc = m_pc + 32'd4;
      end
    end
    checks++; if (addrs.size() < 4 || acc_at.size() < 5) begin
      errors++; $display("FAIL zl_count reqs %0d accepts %0d exp >=4 >=5", addrs.size(), acc_at.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (addrs[k] !== 32'(4 * k)) begin errors++; $display("FAIL zl_addr%0d got %h exp %h", k, addrs[k], 32'(4 * k)); end
      end
      for (int k = 1; k < acc_at.size(); k++) begin
        checks++; if (acc_at[k] - acc_at[k-1] != 2) begin errors++; $display("FAIL zl_spacing got %0d exp 2", acc_at[k] - acc_at[k-1]); end
      end
    end
    rv_lat = 1;
    wait_valid(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    flush = 1; flush_pc = 32'hFFFF_FFFC; @(negedge clk); flush = 0;
    m_pc = 32'hFFFF_FFFC;
    wait_valid(ok);
    checks++; if (!ok || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc ok %b pc %h pc4 %h exp fffffffc 0", ok, pc, pc_plus4);
    end
    instr_ready = 1; @(negedge clk); instr_ready = 0;
    m_pc = 32'h0;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req ok %b addr %h exp 0", ok, imem_addr); end
    wait_valid(ok);
  endtask

  task automatic test_misalign();
    bit ok;
    instr_ready = 1; PCSrc = 1; pc_target = 32'h42;
    @(negedge clk);
    instr_ready = 0; PCSrc = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL misal_flag got %b exp 1", fetch_misaligned); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin
        errors++; $display("FAIL misal_halt req %b v %b flag %b exp 0 0 1", imem_req, instr_valid, fetch_misaligned);
      end
    end
    flush = 1; flush_pc = 32'h0; @(negedge clk); flush = 0;
    m_pc = 32'h0;
    checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL misal_clear got %b exp 0", fetch_misaligned); end
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h0) begin errors++; $display("FAIL misal_resume ok %b addr %h exp 0", ok, imem_addr); end
`else
    m_pc = 32'h40;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h40) begin errors++; $display("FAIL align_target ok %b addr %h exp 40", ok, imem_addr); end
    wait_valid(ok);
    flush = 1; flush_pc = 32'h103; @(negedge clk); flush = 0;
    m_pc = 32'h100;
    wait_gnt(ok);
    checks++; if (!ok || imem_addr !== 32'h100) begin errors++; $display("FAIL align_flush ok %b addr %h exp 100", ok, imem_addr); end
`endif
    wait_valid(ok);
  endtask

  task automatic test_random_stream(input int n);
    int acc = 0;
    for (int cyc = 0; cyc < 20000 && acc < n; cyc++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr got %h exp %h", imem_addr, m_pc); end
      end
      if (imem_req && instr_valid) begin errors++; checks++; $display("FAIL rnd_req_in_hold req %b v %b exp not both", imem_req, instr_valid); end
      if (instr_valid) begin
        checks++; if (pc !== m_pc || instruction !== mem_word(m_pc) || pc_plus4 !== m_pc + 32'd4 || fetch_busy !== 1'b0) begin
          errors++; $display("FAIL rnd_instr pc %h instr %h pc4 %h busy %b exp %h %h %h 0", pc, instruction, pc_plus4, fetch_busy, m_pc, mem_word(m_pc), m_pc + 32'd4);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      flush_pc = $urandom;
      instr_ready = instr_valid && ($urandom_range(0, 2) != 0);
      PCSrc = ($urandom_range(0, 3) == 0);
      pc_target = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      flush_pc[1:0] = 2'b00;
      pc_target[1:0] = 2'b00;
`endif
      if (flush) begin
        m_pc = align(flush_pc);
      end else if (instr_ready) begin
        m_pc = PCSrc ? align(pc_target) : m_pc + 32'd4;
        acc++;
        gnt_lat = $urandom_range(0, 2);
        rv_lat = $urandom_range(0, 3);
      end
    end
    checks++; if (acc < n) begin errors++; $display("FAIL rnd_progress got %0d exp %0d", acc, n); end
    @(negedge clk);
    flush = 0; instr_ready = 0; PCSrc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_branch();
    test_flush_wait();
    test_zero_latency();
    test_wrap();
    test_misalign();
    test_random_stream(300);
    test_reset();
    test_first_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
